// File: rtl/serial_feeder_pkg.sv
// serial_feeder_pkg: shared state type and line level for the serial word feeder
package serial_feeder_pkg;
  typedef enum logic {IDLE, SHIFT} feeder_state_t;
  localparam logic IDLE_LEVEL = 1'b0;
endpackage

// File: rtl/feeder_hold_reg.sv
// feeder_hold_reg: one-entry pending word buffer with load/pop/full
module feeder_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q <= '0;
      full <= 1'b0;
    end else begin
      if (load) q <= d;
      full <= load | (full & ~pop);
    end
endmodule

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: accepts words over valid/ready and shifts them out one bit per clock
module serial_word_feeder
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  feeder_state_t state, state_n;
  logic [WIDTH-1:0] sh, sh_n, pend;
  logic [CW-1:0] cnt, cnt_n;
  logic pend_full, acc, shifting, last, load, push, pop, bit_out;
  feeder_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk,
    .rst,
    .load(push),
    .pop,
    .d(in_data),
    .q(pend),
    .full(pend_full)
  );
  // load: a word enters the shifter; push: an accepted word must wait in pend
  always_comb begin
    in_ready = !pend_full;
    acc = in_valid && in_ready;
    shifting = state == SHIFT;
    last = shifting && cnt == CW'(WIDTH - 1);
    pop = last && pend_full;
    load = (!shifting && acc) || (last && (pend_full || acc));
    push = acc && shifting && !(last && !pend_full);
    bit_out = LSB_FIRST ? sh[0] : sh[WIDTH-1];
    busy = shifting || pend_full;
    state_n = load ? SHIFT : (last ? IDLE : state);
    sh_n = load ? (pop ? pend : in_data) : (shifting ? (LSB_FIRST ? sh >> 1 : sh << 1) : sh);
    cnt_n = load ? '0 : (shifting ? cnt + 1'b1 : cnt);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sh <= '0;
      cnt <= '0;
      x <= IDLE_LEVEL;
      x_valid <= 1'b0;
      word_done <= 1'b0;
    end else begin
      sh <= sh_n;
      cnt <= cnt_n;
      x <= shifting ? bit_out : IDLE_LEVEL;
      x_valid <= shifting;
      word_done <= last;
    end
endmodule

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder: vector table, corner sequences and random traffic against a word-queue model
module tb_serial_word_feeder;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] lsb_bits;
    logic [W-1:0] msb_bits;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic x_l, xv_l, wd_l, rdy_l, busy_l;
  logic x_m, xv_m, wd_m, rdy_m, busy_m;
  int checks = 0, failures = 0, pos = 0, cyc = 0;
  logic [W-1:0] wq[$];
  logic last_acc = 1'b0;
  vec_t vt[6];
  always #5 clk = ~clk;
  serial_word_feeder #(.WIDTH(W), .LSB_FIRST(1'b1)) u_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_l),
    .x(x_l), .x_valid(xv_l), .word_done(wd_l), .busy(busy_l)
  );
  serial_word_feeder #(.WIDTH(W), .LSB_FIRST(1'b0)) u_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_m),
    .x(x_m), .x_valid(xv_m), .word_done(wd_m), .busy(busy_m)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // The model holds whole words; a word leaves once its last bit has been emitted.
  task automatic step();
    logic a, el, em, ev, ed;
    a = in_valid && (wq.size() < 2);
    @(posedge clk);
    cyc++;
    if (wq.size() > 0) begin
      el = wq[0][pos];
      em = wq[0][W-1-pos];
      ev = 1'b1;
      ed = pos == W - 1;
      if (ed) begin
        wq.delete(0);
        pos = 0;
      end else pos++;
    end else begin
      el = 1'b0; em = 1'b0; ev = 1'b0; ed = 1'b0;
    end
    if (a) wq.push_back(in_data);
    last_acc = a;
    #1;
    chk("x_lsb", x_l, el);
    chk("x_msb", x_m, em);
    chk("x_valid", {xv_l, xv_m}, {ev, ev});
    chk("word_done", {wd_l, wd_m}, {ed, ed});
    chk("in_ready", {rdy_l, rdy_m}, {2{wq.size() < 2}});
    chk("busy", {busy_l, busy_m}, {2{wq.size() > 0}});
  endtask
  initial begin
    int run, maxrun, k, wd1, acc3;
    logic saw_nr;
    logic [W-1:0] w3[3];
    vt[0] = '{8'hB5, 8'hB5, 8'hAD};
    vt[1] = '{8'hFF, 8'hFF, 8'hFF};
    vt[2] = '{8'h00, 8'h00, 8'h00};
    vt[3] = '{8'h01, 8'h01, 8'h80};
    vt[4] = '{8'h80, 8'h80, 8'h01};
    vt[5] = '{8'hC3, 8'hC3, 8'hC3};
    w3[0] = 8'h11; w3[1] = 8'h22; w3[2] = 8'h33;
    #12;
    chk("rst_outputs", {x_l, xv_l, wd_l, busy_l, x_m, xv_m, wd_m, busy_m}, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_release", {rdy_l, busy_l, rdy_m, busy_m}, 4'b1010);
    foreach (vt[i]) begin
      in_valid = 1'b1;
      in_data = vt[i].data;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("tbl_accept", {busy_l, xv_l, x_l}, 3'b100);
      for (int b = 0; b < W; b++) begin
        @(posedge clk); #1;
        chk("tbl_x_lsb", x_l, vt[i].lsb_bits[b]);
        chk("tbl_x_msb", x_m, vt[i].msb_bits[b]);
        chk("tbl_valid", {xv_l, xv_m}, 2'b11);
        chk("tbl_done", {wd_l, wd_m}, {2{b == W - 1}});
      end
      @(posedge clk); #1;
      chk("tbl_idle", {x_l, x_m, xv_l, xv_m, wd_l, wd_m, busy_l}, 0);
    end
    in_valid = 1'b1; in_data = 8'hFF; run = 0; maxrun = 0; saw_nr = 1'b0;
    for (int t = 0; t < 30; t++) begin
      step();
      if (last_acc && in_data == 8'hFF) in_data = 8'h00;
      else if (last_acc) in_valid = 1'b0;
      run = xv_l ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (!rdy_l) saw_nr = 1'b1;
    end
    chk("b2b_run", maxrun, 16);
    chk("b2b_ready_drop", saw_nr, 1'b1);
    k = 0; wd1 = -1; acc3 = -1;
    in_valid = 1'b1; in_data = w3[0];
    for (int t = 0; t < 40; t++) begin
      step();
      if (wd_l && wd1 < 0) wd1 = cyc;
      if (last_acc) begin
        if (k == 2) acc3 = cyc;
        k++;
        if (k < 3) in_data = w3[k];
        else in_valid = 1'b0;
      end
    end
    chk("three_accepted", k, 3);
    chk("third_after_done", acc3, wd1 + 1);
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    for (int t = 0; t < 3; t++) step();
    #2 rst = 1'b0;
    #1;
    chk("async_rst", {x_l, x_m, xv_l, xv_m, wd_l, wd_m, busy_l, busy_m}, 0);
    chk("async_rst_ready", {rdy_l, rdy_m}, 2'b11);
    wq.delete();
    pos = 0;
    last_acc = 1'b0;
    @(negedge clk) rst = 1'b1;
    in_valid = 1'b1; in_data = 8'h3C;
    step();
    in_valid = 1'b0;
    for (int t = 0; t < 12; t++) step();
    for (int t = 0; t < 400; t++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = $urandom_range(0, 9) < (((t / 50) % 2) != 0 ? 9 : 2);
        in_data = W'($urandom);
      end
      step();
    end
    in_valid = 1'b0;
    for (int t = 0; t < 20; t++) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
